// File: rtl/sum_pkg.sv
// rtl/sum_pkg.sv - shared state encoding and default widths for the window accumulator
package sum_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 16;
    localparam int CNT_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/sum_accum.sv
// rtl/sum_accum.sv - windowed accumulator for the adder's sum stream with held result handshake
module sum_accum
    import sum_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              abort,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    state_t             state;
    state_t             state_next;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   len_q;
    logic               ovf;

    logic               take_start;
    logic               accept;
    logic               last_sample;
    logic [CNT_W-1:0]   cnt_inc;
    logic [ACC_W:0]     sum_ext;

    // Abort beats every other request, so it gates both start and sample acceptance.
    assign take_start  = (state == IDLE) && start && !abort;
    assign accept      = (state == ACCUM) && in_valid && !abort;
    assign cnt_inc     = cnt + CNT_W'(1);
    assign last_sample = accept && (cnt_inc == len_q);
    // One extra bit captures the carry out of the accumulator for the sticky wrap flag.
    assign sum_ext     = {1'b0, acc} + (ACC_W + 1)'(in_data);

    // Handshake and status outputs come straight from the state register.
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);
    assign out_acc   = acc;
    assign out_count = cnt;
    assign out_ovf   = ovf;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: empty windows go straight to HOLD with a zero result.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (take_start) begin
                    state_next = (len != '0) ? ACCUM : HOLD;
                end
            end
            ACCUM: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (last_sample) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (abort || out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Window datapath: clear on start, add accepted samples, hold everything otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            cnt   <= '0;
            len_q <= '0;
            ovf   <= 1'b0;
        end else if (take_start) begin
            acc   <= '0;
            cnt   <= '0;
            len_q <= len;
            ovf   <= 1'b0;
        end else if (accept) begin
            acc <= sum_ext[ACC_W-1:0];
            cnt <= cnt_inc;
            if (sum_ext[ACC_W]) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sum_accum.sv
// tb/tb_sum_accum.sv - directed-vector bench for sum_accum
module tb_sum_accum;

    logic        clk = 1'b0;
    logic        rst;

    logic        start, abort, in_valid, out_ready;
    logic [7:0]  len, in_data;
    logic        in_ready, out_ovf, out_valid, busy;
    logic [15:0] out_acc;
    logic [7:0]  out_count;

    logic        start8, abort8, in_valid8, out_ready8;
    logic [7:0]  len8, in_data8;
    logic        in_ready8, out_ovf8, out_valid8, busy8;
    logic [7:0]  out_acc8;
    logic [7:0]  out_count8;

    int vectors;
    int miscompares;

    always #5 clk = ~clk;

    sum_accum #(.DATA_W(8), .ACC_W(16), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_acc(out_acc), .out_count(out_count), .out_ovf(out_ovf),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    sum_accum #(.DATA_W(8), .ACC_W(8), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .len(len8), .abort(abort8),
        .in_data(in_data8), .in_valid(in_valid8), .in_ready(in_ready8),
        .out_acc(out_acc8), .out_count(out_count8), .out_ovf(out_ovf8),
        .out_valid(out_valid8), .out_ready(out_ready8), .busy(busy8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; abort = 0; in_valid = 0; out_ready = 0; len = 0; in_data = 0;
        start8 = 0; abort8 = 0; in_valid8 = 0; out_ready8 = 0; len8 = 0; in_data8 = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        vectors++;
        if ({busy, in_ready, out_valid, out_ovf} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags got=%b want=0000", {busy, in_ready, out_valid, out_ovf});
        end
        vectors++;
        if (out_acc !== 16'd0 || out_count !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_regs acc=%0d cnt=%0d want 0/0", out_acc, out_count);
        end
        rst = 0;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] samples [4];
        samples[0] = 10; samples[1] = 20; samples[2] = 30; samples[3] = 40;
        out_ready = 1;
        start = 1; len = 4;
        tick();
        start = 0;
        vectors++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_enter_accum in_ready=%b busy=%b want 1/1", in_ready, busy);
        end
        in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            in_data = samples[i];
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL basic_early_valid sample=%0d out_valid=%b want 0", i, out_valid);
            end
            tick();
        end
        in_valid = 0;
        vectors++;
        if (out_valid !== 1'b1 || out_acc !== 16'd100 || out_count !== 8'd4 || out_ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_result valid=%b acc=%0d cnt=%0d ovf=%b want 1/100/4/0",
                     out_valid, out_acc, out_count, out_ovf);
        end
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_hold_in_ready got=%b want 0", in_ready);
        end
        tick();
        vectors++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_back_idle busy=%b valid=%b want 0/0", busy, out_valid);
        end
        out_ready = 0;
    endtask

    task automatic test_zero_len();
        start = 1; len = 0;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_in_ready_idle got=%b want 0", in_ready);
        end
        tick();
        start = 0;
        vectors++;
        if (out_valid !== 1'b1 || out_acc !== 16'd0 || out_count !== 8'd0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_hold valid=%b acc=%0d cnt=%0d in_ready=%b want 1/0/0/0",
                     out_valid, out_acc, out_count, in_ready);
        end
        out_ready = 1;
        tick();
        out_ready = 0;
        vectors++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_back_idle busy=%b in_ready=%b want 0/0", busy, in_ready);
        end
    endtask

    task automatic test_overflow();
        start8 = 1; len8 = 2;
        tick();
        start8 = 0;
        in_valid8 = 1; in_data8 = 200;
        tick();
        in_data8 = 100;
        tick();
        in_valid8 = 0;
        vectors++;
        if (out_valid8 !== 1'b1 || out_acc8 !== 8'd44 || out_ovf8 !== 1'b1 || out_count8 !== 8'd2) begin
            miscompares++;
            $display("FAIL ovf_result valid=%b acc=%0d ovf=%b cnt=%0d want 1/44/1/2",
                     out_valid8, out_acc8, out_ovf8, out_count8);
        end
        out_ready8 = 1;
        tick();
        out_ready8 = 0;
        vectors++;
        if (busy8 !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_back_idle busy=%b want 0", busy8);
        end
    endtask

    task automatic test_backpressure();
        int handshakes;
        start = 1; len = 1;
        tick();
        start = 0;
        in_valid = 1; in_data = 7;
        tick();
        for (int i = 0; i < 5; i++) begin
            start = i[0]; in_valid = ~i[0]; in_data = 99; len = 3;
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_acc !== 16'd7 || out_count !== 8'd1 ||
                out_ovf !== 1'b0 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_stable cyc=%0d valid=%b acc=%0d cnt=%0d ovf=%b in_ready=%b want 1/7/1/0/0",
                         i, out_valid, out_acc, out_count, out_ovf, in_ready);
            end
        end
        in_valid = 0;
        start = 1;
        out_ready = 1;
        handshakes = 0;
        for (int i = 0; i < 3; i++) begin
            if (out_valid && out_ready) handshakes++;
            tick();
            start = 0;
        end
        out_ready = 0;
        vectors++;
        if (handshakes !== 1) begin
            miscompares++;
            $display("FAIL bp_handshakes got=%0d want 1", handshakes);
        end
        vectors++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_start_ignored busy=%b valid=%b want 0/0", busy, out_valid);
        end
    endtask

    task automatic test_abort_reset();
        int seen_valid;
        start = 1; len = 5;
        tick();
        start = 0;
        in_valid = 1; in_data = 1;
        tick();
        in_data = 2;
        tick();
        in_data = 50; abort = 1;
        tick();
        abort = 0; in_valid = 0;
        vectors++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_acc !== 16'd3 || out_count !== 8'd2) begin
            miscompares++;
            $display("FAIL abort_mid busy=%b valid=%b acc=%0d cnt=%0d want 0/0/3/2",
                     busy, out_valid, out_acc, out_count);
        end
        seen_valid = 0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid) seen_valid++;
            tick();
        end
        vectors++;
        if (seen_valid !== 0) begin
            miscompares++;
            $display("FAIL abort_no_result valid_cycles=%0d want 0", seen_valid);
        end
        start = 1; len = 5;
        tick();
        start = 0;
        in_valid = 1; in_data = 9;
        tick();
        tick();
        rst = 1;
        tick();
        rst = 0; in_valid = 0;
        vectors++;
        if (out_acc !== 16'd0 || out_count !== 8'd0 ||
            {out_ovf, out_valid, in_ready, busy} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_mid acc=%0d cnt=%0d flags=%b want 0/0/0000",
                     out_acc, out_count, {out_ovf, out_valid, in_ready, busy});
        end
        start = 1; abort = 1; len = 3;
        tick();
        start = 0; abort = 0;
        vectors++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_start_idle busy=%b in_ready=%b want 0/0", busy, in_ready);
        end
    endtask

    task automatic test_max_len();
        start = 1; len = 255;
        tick();
        start = 0;
        in_valid = 1; in_data = 1;
        for (int i = 0; i < 255; i++) tick();
        in_valid = 0;
        vectors++;
        if (out_valid !== 1'b1 || out_count !== 8'd255 || out_acc !== 16'd255 || out_ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL maxlen_result valid=%b cnt=%0d acc=%0d ovf=%b want 1/255/255/0",
                     out_valid, out_count, out_acc, out_ovf);
        end
        out_ready = 1;
        tick();
        out_ready = 0;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL maxlen_back_idle busy=%b want 0", busy);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1;
        test_reset();
        test_basic();
        test_zero_len();
        test_overflow();
        test_backpressure();
        test_abort_reset();
        test_max_len();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
